l2_arbiter: RTL and testbench
=============================

Name: l2_arbiter

Overview:
- Shares the single unified L2 cache port between the L1 instruction cache and the L1 data cache.
- Sits between both L1 miss/writeback ports and the L2 CPU-side port (mem_read/mem_write/resp).
- Grants one requester at a time with round-robin priority.
- Forwards the granted request combinationally and routes the L2 resp back only to the owner.
- Keeps saturating per-requester grant counters for performance debug.

Parameters:
ADDR_WIDTH, 32, line-address width forwarded to L2
LINE_WIDTH, 256, cacheline data width
CNT_WIDTH, 16, width of saturating grant counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_mem_read  in  1  I-cache line read request
i_mem_address  in  ADDR_WIDTH  I-cache line address
i_mem_rdata  out  LINE_WIDTH  line data to I-cache
i_mem_resp  out  1  I-cache completion, one cycle
d_mem_read  in  1  D-cache line read request
d_mem_write  in  1  D-cache line writeback request
d_mem_address  in  ADDR_WIDTH  D-cache line address
d_mem_wdata  in  LINE_WIDTH  D-cache writeback data
d_mem_rdata  out  LINE_WIDTH  line data to D-cache
d_mem_resp  out  1  D-cache completion, one cycle
l2_mem_read  out  1  read to L2
l2_mem_write  out  1  write to L2
l2_mem_address  out  ADDR_WIDTH  address to L2
l2_mem_wdata  out  LINE_WIDTH  write data to L2
l2_mem_rdata  in  LINE_WIDTH  L2 read data
l2_mem_resp  in  1  L2 completion
i_grant_cnt  out  CNT_WIDTH  completed I transactions, saturating
d_grant_cnt  out  CNT_WIDTH  completed D transactions, saturating

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Priority register prio: 0 means D is favoured, 1 means I is favoured.
- Reset (asynchronous, active-high, may assert mid-transaction):
  - Cycle-level effect: state goes to IDLE, prio to 0, both counters to 0.
  - Outputs: all l2_* controls and both resps are 0.
  - Mid-transaction: an in-flight transaction is abandoned and no resp is issued.
- IDLE:
  - Nothing is forwarded to L2; l2_mem_read and l2_mem_write are 0.
  - Next state: if only I requests, go to SERVE_I. If only D requests (read or write), go to SERVE_D.
  - If both request: go to SERVE_D when prio=0, SERVE_I when prio=1.
  - If neither requests, stay in IDLE.
  - Arbitration costs exactly one bubble cycle. The first L2-visible cycle is the cycle after the request is first seen in IDLE.
- SERVE_I:
  - l2_mem_read = i_mem_read, l2_mem_address = i_mem_address, l2_mem_write = 0.
  - Routing: i_mem_resp = l2_mem_resp and i_mem_rdata = l2_mem_rdata.
- SERVE_D:
  - l2_mem_read = d_mem_read, l2_mem_write = d_mem_write, l2_mem_address = d_mem_address, l2_mem_wdata = d_mem_wdata.
  - Routing: d_mem_resp = l2_mem_resp and d_mem_rdata = l2_mem_rdata.
- Completion: on l2_mem_resp in a SERVE state:
  - next state is IDLE;
  - prio flips to favour the other requester;
  - the owner's counter increments, saturating at all-ones.
- Stay in the SERVE state while l2_mem_resp is 0. There is no timeout.
- Isolation: the non-owner's resp is always 0. Both rdata outputs may mirror l2_mem_rdata at all times; only the resp is qualified.
- Requester contract:
  - The request and its address/data are held stable until resp.
  - The request is deasserted the cycle after resp.
  - The one-cycle IDLE after every completion guarantees a stale request is never re-issued to L2.
- Requester drops its request while being served (protocol violation): outputs follow the inputs and the state is held. The bench flags this.
- d_mem_read and d_mem_write both high: illegal. The bench asserts it never happens; RTL forwards both unchanged.
- Back-to-back L2 hit (resp in the first SERVE cycle): the transaction takes 2 cycles in total.

Decomposition:
- Package l2_arb_pkg:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D};
  - requester_t enum {REQ_D=0, REQ_I=1};
  - default width constants.
- Sub-module rr_arbiter2: a 2-input round-robin grant picker.
  - Inputs: req[1:0], prio.
  - Output: one-hot grant.
  - Combinational; the prio register is held in l2_arbiter.

Test Plan:
- Single I read, address 0x0000_1000, L2 resp 3 cycles after forward, rdata 0xA5..A5 -> i_mem_resp pulses once with that data, d_mem_resp stays 0, i_grant_cnt=1.
- I read and D write asserted in the same cycle just after reset -> D is served first (l2_mem_write=1, D's address/wdata seen), then I; grant order D, I; 1 IDLE cycle between them.
- Continuous requests from both for 6 transactions -> grants strictly alternate D,I,D,I,D,I; both counters = 3.
- rst asserted while SERVE_D is waiting for resp -> l2_mem_write drops to 0 immediately, no d_mem_resp; after release, state is IDLE and D is favoured.
- L2 resp in the first SERVE cycle -> 2-cycle transaction, and a request held for one extra cycle is not re-forwarded.
- Force i_grant_cnt to 0xFFFE, run 3 I reads -> count saturates at 0xFFFF.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// rtl/l2_arb_pkg.sv - shared types and default widths for the L2 port arbiter
package l2_arb_pkg;

   localparam int ADDR_WIDTH_DEF = 32;
   localparam int LINE_WIDTH_DEF = 256;
   localparam int CNT_WIDTH_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

   // Doubles as the bit index into the req/grant vectors.
   typedef enum logic {
      REQ_D = 1'b0,
      REQ_I = 1'b1
   } requester_t;

endpackage

// File: rtl/l2_arbiter_if.sv
// rtl/l2_arbiter_if.sv - L1 I/D miss ports and L2 CPU-side port bundled as one bus
interface l2_arbiter_if
   import l2_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int LINE_WIDTH = LINE_WIDTH_DEF
);
   logic                  i_mem_read;
   logic [ADDR_WIDTH-1:0] i_mem_address;
   logic [LINE_WIDTH-1:0] i_mem_rdata;
   logic                  i_mem_resp;

   logic                  d_mem_read;
   logic                  d_mem_write;
   logic [ADDR_WIDTH-1:0] d_mem_address;
   logic [LINE_WIDTH-1:0] d_mem_wdata;
   logic [LINE_WIDTH-1:0] d_mem_rdata;
   logic                  d_mem_resp;

   logic                  l2_mem_read;
   logic                  l2_mem_write;
   logic [ADDR_WIDTH-1:0] l2_mem_address;
   logic [LINE_WIDTH-1:0] l2_mem_wdata;
   logic [LINE_WIDTH-1:0] l2_mem_rdata;
   logic                  l2_mem_resp;

   // slave: the arbiter's view; master: the L1s plus L2 environment.
   modport slave (
      input  i_mem_read, i_mem_address,
      output i_mem_rdata, i_mem_resp,
      input  d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
      output d_mem_rdata, d_mem_resp,
      output l2_mem_read, l2_mem_write, l2_mem_address, l2_mem_wdata,
      input  l2_mem_rdata, l2_mem_resp
   );

   modport master (
      output i_mem_read, i_mem_address,
      input  i_mem_rdata, i_mem_resp,
      output d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
      input  d_mem_rdata, d_mem_resp,
      input  l2_mem_read, l2_mem_write, l2_mem_address, l2_mem_wdata,
      output l2_mem_rdata, l2_mem_resp
   );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin grant picker
module rr_arbiter2
   import l2_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       prio,
   output logic [1:0] grant
);

   // prio=1 favours I on a tie, prio=0 favours D.
   always_comb begin
      grant = 2'b00;
      if (req[REQ_I] && (!req[REQ_D] || prio)) begin
         grant[REQ_I] = 1'b1;
      end else if (req[REQ_D]) begin
         grant[REQ_D] = 1'b1;
      end
   end

endmodule

// File: rtl/l2_arbiter.sv
// rtl/l2_arbiter.sv - round-robin sharing of the unified L2 port between I and D L1 caches
module l2_arbiter
   import l2_arb_pkg::*;
#(
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
)(
   input  logic                 clk,
   input  logic                 rst,
   l2_arbiter_if.slave          bus,
   output logic [CNT_WIDTH-1:0] i_grant_cnt,
   output logic [CNT_WIDTH-1:0] d_grant_cnt
);

   arb_state_t           state, state_nxt;
   logic                 prio, prio_nxt;
   logic [1:0]           req, grant;
   logic                 done_i, done_d;
   logic [CNT_WIDTH-1:0] i_cnt, d_cnt;

   assign req[REQ_I] = bus.i_mem_read;
   assign req[REQ_D] = bus.d_mem_read | bus.d_mem_write;

   rr_arbiter2 u_rr (
      .req   (req),
      .prio  (prio),
      .grant (grant)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         prio  <= 1'b0;
         i_cnt <= '0;
         d_cnt <= '0;
      end else begin
         state <= state_nxt;
         prio  <= prio_nxt;
         if (done_i && !(&i_cnt)) i_cnt <= i_cnt + CNT_WIDTH'(1);
         if (done_d && !(&d_cnt)) d_cnt <= d_cnt + CNT_WIDTH'(1);
      end
   end

   // Serve states forward the owner combinationally; IDLE is the one-cycle arbitration bubble.
   always_comb begin
      state_nxt          = state;
      prio_nxt           = prio;
      done_i             = 1'b0;
      done_d             = 1'b0;
      bus.l2_mem_read    = 1'b0;
      bus.l2_mem_write   = 1'b0;
      bus.l2_mem_address = '0;
      bus.l2_mem_wdata   = '0;
      bus.i_mem_resp     = 1'b0;
      bus.d_mem_resp     = 1'b0;
      case (state)
         IDLE: begin
            if (grant[REQ_I])      state_nxt = SERVE_I;
            else if (grant[REQ_D]) state_nxt = SERVE_D;
         end
         SERVE_I: begin
            bus.l2_mem_read    = bus.i_mem_read;
            bus.l2_mem_address = bus.i_mem_address;
            bus.i_mem_resp     = bus.l2_mem_resp;
            if (bus.l2_mem_resp) begin
               state_nxt = IDLE;
               prio_nxt  = 1'b0;
               done_i    = 1'b1;
            end
         end
         SERVE_D: begin
            bus.l2_mem_read    = bus.d_mem_read;
            bus.l2_mem_write   = bus.d_mem_write;
            bus.l2_mem_address = bus.d_mem_address;
            bus.l2_mem_wdata   = bus.d_mem_wdata;
            bus.d_mem_resp     = bus.l2_mem_resp;
            if (bus.l2_mem_resp) begin
               state_nxt = IDLE;
               prio_nxt  = 1'b1;
               done_d    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.i_mem_rdata = bus.l2_mem_rdata;
   assign bus.d_mem_rdata = bus.l2_mem_rdata;
   assign i_grant_cnt     = i_cnt;
   assign d_grant_cnt     = d_cnt;

endmodule

// File: tb/tb_l2_arbiter.sv
// tb/tb_l2_arbiter.sv - directed bench for l2_arbiter with a transaction-level reference model
module tb_l2_arbiter;

   logic        clk;
   logic        rst;
   logic [15:0] i_grant_cnt, d_grant_cnt;

   l2_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) bus ();

   l2_arbiter #(.CNT_WIDTH(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .i_grant_cnt (i_grant_cnt),
      .d_grant_cnt (d_grant_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // L2 stub: fixed latency counted from the first forwarded cycle, or zero latency when fast.
   int           lat = 1;
   bit           fast = 1'b0;
   logic         resp_reg = 1'b0;
   int           vis_cnt = 0;
   logic [255:0] l2_rdata = '0;

   assign bus.l2_mem_resp  = fast ? (bus.l2_mem_read | bus.l2_mem_write) : resp_reg;
   assign bus.l2_mem_rdata = l2_rdata;

   always @(negedge clk) begin
      if (rst) vis_cnt = 0;
      else if ((bus.l2_mem_read || bus.l2_mem_write) && !bus.l2_mem_resp) vis_cnt = vis_cnt + 1;
      else vis_cnt = 0;
   end

   always @(posedge clk) begin
      #1;
      resp_reg = !rst && !fast && (lat > 0) && (vis_cnt == lat);
   end

   // Reference model: owner 0 = none, 1 = I, 2 = D.
   int m_owner = 0;
   bit m_prio  = 1'b0;
   int m_icnt  = 0;
   int m_dcnt  = 0;
   localparam int CMAX = 65535;

   function automatic bit m_resp();
      bit rd, wr;
      rd = (m_owner == 1) ? bus.i_mem_read : (m_owner == 2) ? bus.d_mem_read : 1'b0;
      wr = (m_owner == 2) ? bus.d_mem_write : 1'b0;
      return fast ? (rd | wr) : resp_reg;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner = 0;
         m_prio  = 1'b0;
         m_icnt  = 0;
         m_dcnt  = 0;
      end else begin
         bit ri, rd, r;
         ri = bus.i_mem_read;
         rd = bus.d_mem_read | bus.d_mem_write;
         r  = m_resp();
         if (m_owner == 0) begin
            if (ri && rd) m_owner = m_prio ? 1 : 2;
            else if (ri)  m_owner = 1;
            else if (rd)  m_owner = 2;
         end else if (r) begin
            if (m_owner == 1) begin
               m_icnt = (m_icnt < CMAX) ? m_icnt + 1 : CMAX;
               m_prio = 1'b0;
            end else begin
               m_dcnt = (m_dcnt < CMAX) ? m_dcnt + 1 : CMAX;
               m_prio = 1'b1;
            end
            m_owner = 0;
         end
      end
   end

   int i_pulses = 0;
   int d_pulses = 0;
   int pv_owner = 0;
   bit pv_pend  = 1'b0;

   always @(negedge clk) begin : compare
      logic        e_rd, e_wr, e_r, cur_req;
      logic [31:0] e_addr;
      e_r  = m_resp();
      e_rd = (m_owner == 1) ? bus.i_mem_read : (m_owner == 2) ? bus.d_mem_read : 1'b0;
      e_wr = (m_owner == 2) ? bus.d_mem_write : 1'b0;
      chk("l2_mem_read", bus.l2_mem_read, e_rd);
      chk("l2_mem_write", bus.l2_mem_write, e_wr);
      chk("i_mem_resp", bus.i_mem_resp, (m_owner == 1) && e_r);
      chk("d_mem_resp", bus.d_mem_resp, (m_owner == 2) && e_r);
      if (m_owner != 0) begin
         e_addr = (m_owner == 1) ? bus.i_mem_address : bus.d_mem_address;
         chk("l2_mem_address", bus.l2_mem_address, e_addr);
      end
      if (m_owner == 2) chk("l2_mem_wdata", bus.l2_mem_wdata, bus.d_mem_wdata);
      chk("i_mem_rdata", bus.i_mem_rdata, l2_rdata);
      chk("d_mem_rdata", bus.d_mem_rdata, l2_rdata);
      chk("i_grant_cnt", i_grant_cnt, m_icnt[15:0]);
      chk("d_grant_cnt", d_grant_cnt, m_dcnt[15:0]);
      if (bus.d_mem_read && bus.d_mem_write) chk("d_read_write_exclusive", 1'b1, 1'b0);
      if (bus.i_mem_resp) i_pulses++;
      if (bus.d_mem_resp) d_pulses++;
      cur_req = (m_owner == 1) ? bus.i_mem_read : (bus.d_mem_read | bus.d_mem_write);
      if (pv_pend && m_owner == pv_owner && !cur_req)
         $display("protocol violation: requester %0d dropped its request while being served", m_owner);
      pv_owner = m_owner;
      pv_pend  = (m_owner != 0) && cur_req && !e_r;
   end

   string order = "";

   task automatic i_txn(input logic [31:0] addr, input int extra,
                        output int cyc, output logic [255:0] data);
      bit got = 1'b0;
      cyc  = 0;
      data = '0;
      bus.i_mem_read    = 1'b1;
      bus.i_mem_address = addr;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (bus.i_mem_resp) begin
            got   = 1'b1;
            cyc   = k + 1;
            data  = bus.i_mem_rdata;
            order = {order, "I"};
         end
         @(posedge clk); #1;
      end
      if (!got) chk("i_txn_timeout", 1'b0, 1'b1);
      for (int k = 0; k < extra; k++) begin
         @(posedge clk); #1;
      end
      bus.i_mem_read = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic d_txn(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [255:0] wdata, output logic seen_wr, output logic [31:0] seen_addr);
      bit got = 1'b0;
      seen_wr   = 1'b0;
      seen_addr = '0;
      bus.d_mem_read    = rd;
      bus.d_mem_write   = wr;
      bus.d_mem_address = addr;
      bus.d_mem_wdata   = wdata;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (bus.d_mem_resp) begin
            got       = 1'b1;
            seen_wr   = bus.l2_mem_write;
            seen_addr = bus.l2_mem_address;
            order     = {order, "D"};
         end
         @(posedge clk); #1;
      end
      if (!got) chk("d_txn_timeout", 1'b0, 1'b1);
      bus.d_mem_read  = 1'b0;
      bus.d_mem_write = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int           cyc;
      logic [255:0] data;
      logic         swr;
      logic [31:0]  sadr;
      rst = 1'b1;
      bus.i_mem_read = 1'b0; bus.i_mem_address = '0;
      bus.d_mem_read = 1'b0; bus.d_mem_write = 1'b0;
      bus.d_mem_address = '0; bus.d_mem_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_l2_read", bus.l2_mem_read, 1'b0);
      chk("reset_l2_write", bus.l2_mem_write, 1'b0);
      chk("reset_i_cnt", i_grant_cnt, 16'd0);
      chk("reset_d_cnt", d_grant_cnt, 16'd0);
      @(posedge clk); #1;

      // Single I read, L2 answers 3 cycles after the first forwarded cycle.
      lat = 3; l2_rdata = {32{8'hA5}};
      i_pulses = 0; d_pulses = 0;
      i_txn(32'h0000_1000, 0, cyc, data);
      chk("t1_cycles", cyc, 5);
      chk("t1_rdata", data, {32{8'hA5}});
      chk("t1_i_pulses", i_pulses, 1);
      chk("t1_d_pulses", d_pulses, 0);
      chk("t1_i_cnt", i_grant_cnt, 16'd1);

      // Simultaneous I read and D write after reset: D first.
      do_reset();
      lat = 2; order = ""; l2_rdata = {8{32'h1234_5678}};
      fork
         i_txn(32'h0000_2000, 0, cyc, data);
         d_txn(1'b0, 1'b1, 32'h0000_3000, {8{32'hDEAD_BEEF}}, swr, sadr);
      join
      chk("t2_order", (order == "DI"), 1'b1);
      chk("t2_d_write_seen", swr, 1'b1);
      chk("t2_d_addr_seen", sadr, 32'h0000_3000);

      // Continuous traffic from both: strict alternation.
      do_reset();
      lat = 1; order = "";
      fork
         for (int n = 0; n < 3; n++) i_txn(32'h0000_4000 + n * 32'h40, 0, cyc, data);
         for (int n = 0; n < 3; n++) d_txn(1'b1, 1'b0, 32'h0000_8000 + n * 32'h40, '0, swr, sadr);
      join
      chk("t3_order", (order == "DIDIDI"), 1'b1);
      chk("t3_i_cnt", i_grant_cnt, 16'd3);
      chk("t3_d_cnt", d_grant_cnt, 16'd3);

      // Reset while SERVE_D waits for L2.
      do_reset();
      lat = 10; d_pulses = 0;
      bus.d_mem_write = 1'b1; bus.d_mem_address = 32'h0000_9000; bus.d_mem_wdata = {8{32'hCAFE_F00D}};
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("t4_write_forwarded", bus.l2_mem_write, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("t4_write_drop", bus.l2_mem_write, 1'b0);
      chk("t4_no_d_resp", bus.d_mem_resp, 1'b0);
      @(posedge clk); #1 bus.d_mem_write = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("t4_idle_read", bus.l2_mem_read, 1'b0);
      chk("t4_d_pulses", d_pulses, 0);
      @(posedge clk); #1;
      lat = 2; order = "";
      fork
         i_txn(32'h0000_A000, 0, cyc, data);
         d_txn(1'b1, 1'b0, 32'h0000_B000, '0, swr, sadr);
      join
      chk("t4_d_favoured", (order == "DI"), 1'b1);

      // Zero-latency L2 hit, requester holds one extra cycle.
      do_reset();
      fast = 1'b1;
      i_txn(32'h0000_C000, 1, cyc, data);
      chk("t5_cycles", cyc, 2);
      repeat (3) begin
         @(negedge clk);
         chk("t5_not_reissued", bus.l2_mem_read, 1'b0);
      end
      @(posedge clk); #1;
      i_txn(32'h0000_D000, 0, cyc, data);
      chk("t5_i_cnt", i_grant_cnt, 16'd2);
      fast = 1'b0;

      // Saturation of the I grant counter.
      do_reset();
      lat = 1;
      force dut.i_cnt = 16'hFFFE;
      m_icnt = 65534;
      @(posedge clk); #1;
      release dut.i_cnt;
      for (int n = 0; n < 3; n++) i_txn(32'h0000_E000, 0, cyc, data);
      chk("t6_saturated", i_grant_cnt, 16'hFFFF);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
